// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings and arbitration-mode constants for the slave-port arbiter.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

endpackage

// File: rtl/ahb_arbiter_rr_nport_if.sv
// Request/grant bundle between the bus-matrix input stages and one slave-port arbiter.
interface ahb_arbiter_rr_nport_if #(
  parameter int NUM_PORTS = 4
);
  localparam int PORT_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] req_port;
  logic                 HREADYM;
  logic                 HSELM;
  logic [1:0]           HTRANSM;
  logic [2:0]           HBURSTM;
  logic                 HMASTLOCKM;
  logic [PORT_W-1:0]    addr_in_port;
  logic                 no_port;
  logic [NUM_PORTS-1:0] grant_onehot;
  logic                 burst_hold;

  modport master (
    output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port, grant_onehot, burst_hold
  );

  modport slave (
    input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port, grant_onehot, burst_hold
  );

endinterface

// File: rtl/ahb_arb_burst_ctr.sv
// Tracks beats left in the granted burst and whether the grant must be held.
// next_hold is combinational from the current beat; state advances only when HREADYM=1.
module ahb_arb_burst_ctr
  import ahb_arb_pkg::*;
#(
  parameter int INCR_HOLD_BEATS = 4,
  parameter int EARLY_INCR_MAX  = 1
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  output logic       next_hold,
  output logic       burst_hold
);

  localparam logic [3:0] INCR_REMAIN = 4'(INCR_HOLD_BEATS - 2);
  localparam logic [1:0] EARLY_MAX   = 2'(EARLY_INCR_MAX);

  logic [3:0] remain_q, remain_d;
  logic       hold_q;
  logic [1:0] early_q, early_d;

  always_comb begin
    remain_d  = remain_q;
    next_hold = hold_q;
    if (!HSELM || HTRANSM == HTRANS_IDLE) begin
      remain_d  = '0;
      next_hold = 1'b0;
    end else begin
      case (HTRANSM)
        HTRANS_NONSEQ: begin
          case (HBURSTM)
            HBURST_INCR16, HBURST_WRAP16: begin remain_d = 4'd14; next_hold = 1'b1; end
            HBURST_INCR8,  HBURST_WRAP8:  begin remain_d = 4'd6;  next_hold = 1'b1; end
            HBURST_INCR4,  HBURST_WRAP4:  begin remain_d = 4'd2;  next_hold = 1'b1; end
            HBURST_INCR: begin
              // Repeated short INCR bursts stop earning a hold once the limit is hit.
              if (early_q == EARLY_MAX) begin
                remain_d  = '0;
                next_hold = 1'b0;
              end else begin
                remain_d  = INCR_REMAIN;
                next_hold = 1'b1;
              end
            end
            default: begin remain_d = '0; next_hold = 1'b0; end
          endcase
        end
        HTRANS_SEQ: begin
          if (remain_q == '0) next_hold = 1'b0;
          else                remain_d  = remain_q - 4'd1;
        end
        default: ;
      endcase
    end

    early_d = early_q;
    if (!next_hold)
      early_d = '0;
    else if (hold_q && HTRANSM == HTRANS_NONSEQ && early_q != 2'd3)
      early_d = early_q + 2'd1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      remain_q <= '0;
      hold_q   <= 1'b0;
      early_q  <= '0;
    end else if (HREADYM) begin
      remain_q <= remain_d;
      hold_q   <= next_hold;
      early_q  <= early_d;
    end
  end

  assign burst_hold = hold_q;

endmodule

// File: rtl/ahb_arbiter_rr_nport.sv
// Slave-port arbiter: picks which input stage owns the slave, holding through locks and bursts.
// Grant registered one cycle after an HREADYM-qualified edge; all state frozen while HREADYM=0.
module ahb_arbiter_rr_nport
  import ahb_arb_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int ARB_MODE        = ARB_RR,
  parameter int INCR_HOLD_BEATS = 4,
  parameter int EARLY_INCR_MAX  = 1
) (
  input logic                   HCLK,
  input logic                   HRESET,
  ahb_arbiter_rr_nport_if.slave bus
);

  localparam int PORT_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;

  logic                 next_hold;
  logic                 burst_hold_w;
  logic [PORT_W-1:0]    idx_q, idx_d, rr_last_q, rr_last_d, scan_start;
  logic                 no_port_q, no_port_d;
  logic [NUM_PORTS-1:0] req_masked;
  logic [PORT_W:0]      pick;

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [PORT_W-1:0] i);
    return NUM_PORTS'(1) << i;
  endfunction

  // First requester after 'start' in wrap order, wrapping at NUM_PORTS-1; MSB = found.
  function automatic logic [PORT_W:0] pick_first(input logic [NUM_PORTS-1:0] req,
                                                 input logic [PORT_W-1:0]    start);
    logic [PORT_W:0]   res;
    logic [PORT_W-1:0] idx;
    int                tmp;
    res = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      tmp = int'(start) + k;
      if (tmp >= NUM_PORTS) tmp = tmp - NUM_PORTS;
      idx = PORT_W'(tmp);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  ahb_arb_burst_ctr #(
    .INCR_HOLD_BEATS (INCR_HOLD_BEATS),
    .EARLY_INCR_MAX  (EARLY_INCR_MAX)
  ) u_burst_ctr (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HREADYM    (bus.HREADYM),
    .HSELM      (bus.HSELM),
    .HTRANSM    (bus.HTRANSM),
    .HBURSTM    (bus.HBURSTM),
    .next_hold  (next_hold),
    .burst_hold (burst_hold_w)
  );

  always_comb begin
    idx_d      = idx_q;
    no_port_d  = no_port_q;
    rr_last_d  = rr_last_q;
    req_masked = bus.req_port;
    scan_start = rr_last_q;
    // An owner competes only against others: masking it lets one scan serve both cases.
    if (!no_port_q) begin
      req_masked = bus.req_port & ~onehot(idx_q);
      scan_start = idx_q;
    end
    if (ARB_MODE == ARB_FIXED) scan_start = PORT_W'(NUM_PORTS - 1);
    pick = pick_first(req_masked, scan_start);

    if (!(bus.HMASTLOCKM || next_hold)) begin
      if (pick[PORT_W]) begin
        idx_d     = pick[PORT_W-1:0];
        no_port_d = 1'b0;
      end else if (no_port_q || !bus.HSELM) begin
        no_port_d = 1'b1;
      end
    end
    if (!no_port_d) rr_last_d = idx_d;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      idx_q     <= '0;
      no_port_q <= 1'b1;
      rr_last_q <= PORT_W'(NUM_PORTS - 1);
    end else if (bus.HREADYM) begin
      idx_q     <= idx_d;
      no_port_q <= no_port_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign bus.addr_in_port = idx_q;
  assign bus.no_port      = no_port_q;
  assign bus.grant_onehot = no_port_q ? '0 : onehot(idx_q);
  assign bus.burst_hold   = burst_hold_w;

endmodule

// File: tb/tb_ahb_arbiter_rr_nport.sv
// Bench for ahb_arbiter_rr_nport: directed vector table, hand-written corner sequences,
// then random traffic on three configurations against a behavioural model.
module tb_ahb_arbiter_rr_nport;
  import ahb_arb_pkg::*;

  logic HCLK;
  logic HRESET;

  logic [3:0] req_a   [3];
  logic       rdy_a   [3];
  logic       sel_a   [3];
  logic [1:0] trans_a [3];
  logic [2:0] burst_a [3];
  logic       lock_a  [3];
  logic [1:0] addr_o  [3];
  logic       nop_o   [3];
  logic [3:0] oh_o    [3];
  logic       hold_o  [3];

  // Configurations: 0 = 4-port RR, 1 = 3-port fixed, 2 = 3-port RR with longer INCR hold.
  int P_N    [3] = '{4, 3, 3};
  int P_MODE [3] = '{0, 1, 0};
  int P_HB   [3] = '{4, 4, 6};
  int P_EM   [3] = '{1, 1, 2};

  int n_cmp = 0;
  int n_bad = 0;

  ahb_arbiter_rr_nport_if #(.NUM_PORTS(4)) if0 ();
  ahb_arbiter_rr_nport_if #(.NUM_PORTS(3)) if1 ();
  ahb_arbiter_rr_nport_if #(.NUM_PORTS(3)) if2 ();

  ahb_arbiter_rr_nport #(.NUM_PORTS(4), .ARB_MODE(ARB_RR), .INCR_HOLD_BEATS(4), .EARLY_INCR_MAX(1))
    dut0 (.HCLK(HCLK), .HRESET(HRESET), .bus(if0));
  ahb_arbiter_rr_nport #(.NUM_PORTS(3), .ARB_MODE(ARB_FIXED), .INCR_HOLD_BEATS(4), .EARLY_INCR_MAX(1))
    dut1 (.HCLK(HCLK), .HRESET(HRESET), .bus(if1));
  ahb_arbiter_rr_nport #(.NUM_PORTS(3), .ARB_MODE(ARB_RR), .INCR_HOLD_BEATS(6), .EARLY_INCR_MAX(2))
    dut2 (.HCLK(HCLK), .HRESET(HRESET), .bus(if2));

  assign if0.req_port = req_a[0];
  assign if1.req_port = req_a[1][2:0];
  assign if2.req_port = req_a[2][2:0];
  assign if0.HREADYM = rdy_a[0];   assign if1.HREADYM = rdy_a[1];   assign if2.HREADYM = rdy_a[2];
  assign if0.HSELM = sel_a[0];     assign if1.HSELM = sel_a[1];     assign if2.HSELM = sel_a[2];
  assign if0.HTRANSM = trans_a[0]; assign if1.HTRANSM = trans_a[1]; assign if2.HTRANSM = trans_a[2];
  assign if0.HBURSTM = burst_a[0]; assign if1.HBURSTM = burst_a[1]; assign if2.HBURSTM = burst_a[2];
  assign if0.HMASTLOCKM = lock_a[0]; assign if1.HMASTLOCKM = lock_a[1]; assign if2.HMASTLOCKM = lock_a[2];
  assign addr_o[0] = if0.addr_in_port; assign addr_o[1] = if1.addr_in_port; assign addr_o[2] = if2.addr_in_port;
  assign nop_o[0] = if0.no_port;       assign nop_o[1] = if1.no_port;       assign nop_o[2] = if2.no_port;
  assign oh_o[0] = if0.grant_onehot;   assign oh_o[1] = {1'b0, if1.grant_onehot};
  assign oh_o[2] = {1'b0, if2.grant_onehot};
  assign hold_o[0] = if0.burst_hold;   assign hold_o[1] = if1.burst_hold;   assign hold_o[2] = if2.burst_hold;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic       sel;
    logic [1:0] tr;
    logic [2:0] bu;
    logic       lk;
    int         ea;
    logic       en;
    logic       eh;
  } vec_t;

  vec_t tv [24];

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic rdy, input logic sel,
                              input logic [1:0] tr, input logic [2:0] bu, input logic lk,
                              input int ea, input logic en, input logic eh);
    vec_t v;
    v.rst = rst; v.req = req; v.rdy = rdy; v.sel = sel; v.tr = tr; v.bu = bu; v.lk = lk;
    v.ea = ea; v.en = en; v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check(input int d, input int ea, input logic en, input logic eh, input string tag);
    logic [3:0] eoh;
    eoh = en ? 4'b0000 : (4'b0001 << ea);
    chk({tag, ".addr_in_port"}, 32'(addr_o[d]), 32'(ea));
    chk({tag, ".no_port"},      32'(nop_o[d]),  32'(en));
    chk({tag, ".grant_onehot"}, 32'(oh_o[d]),   32'(eoh));
    chk({tag, ".burst_hold"},   32'(hold_o[d]), 32'(eh));
  endtask

  task automatic step();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic dvec(input int d, input logic rst, input logic [3:0] req, input logic rdy,
                      input logic sel, input logic [1:0] tr, input logic [2:0] bu, input logic lk,
                      input int ea, input logic en, input logic eh, input string tag);
    HRESET = rst; req_a[d] = req; rdy_a[d] = rdy; sel_a[d] = sel;
    trans_a[d] = tr; burst_a[d] = bu; lock_a[d] = lk;
    step();
    check(d, ea, en, eh, tag);
  endtask

  // Behavioural model state: granted index, no-port flag, last granted, beats left, hold, early count.
  int m_idx [3], m_rr [3], m_rem [3], m_early [3];
  bit m_nop [3], m_hold [3];

  // Beats in a defined-length burst, indexed by HBURST (INCR handled separately).
  int BLEN [8] = '{1, 0, 4, 4, 8, 8, 16, 16};

  task automatic model_step(input int d);
    int n, nr, ne, len, found, c, p, start;
    bit nh;
    logic [3:0] rq;
    n  = P_N[d];
    rq = req_a[d];
    if (HRESET) begin
      m_idx[d] = 0; m_nop[d] = 1; m_rr[d] = n - 1; m_rem[d] = 0; m_hold[d] = 0; m_early[d] = 0;
      return;
    end
    if (!rdy_a[d]) return;

    nr = m_rem[d];
    nh = m_hold[d];
    if (!sel_a[d] || trans_a[d] == HTRANS_IDLE) begin
      nr = 0; nh = 0;
    end else if (trans_a[d] == HTRANS_NONSEQ) begin
      if (burst_a[d] == HBURST_INCR) len = (m_early[d] == P_EM[d]) ? 1 : P_HB[d];
      else                           len = BLEN[burst_a[d]];
      nh = (len > 1);
      nr = nh ? len - 2 : 0;
    end else if (trans_a[d] == HTRANS_SEQ) begin
      if (m_rem[d] == 0) nh = 0;
      else               nr = m_rem[d] - 1;
    end

    if (!nh)                                            ne = 0;
    else if (m_hold[d] && trans_a[d] == HTRANS_NONSEQ)  ne = (m_early[d] < 3) ? m_early[d] + 1 : 3;
    else                                                ne = m_early[d];

    if (!(lock_a[d] || nh)) begin
      c     = m_nop[d] ? -1 : m_idx[d];
      start = m_nop[d] ? m_rr[d] : c;
      found = -1;
      for (int k = 1; k <= n; k++) begin
        p = (P_MODE[d] == 1) ? k - 1 : (start + k) % n;
        if (found < 0 && p != c && rq[p[1:0]]) found = p;
      end
      if (found >= 0) begin
        m_idx[d] = found; m_nop[d] = 0; m_rr[d] = found;
      end else if (m_nop[d] || !sel_a[d]) begin
        m_nop[d] = 1;
      end
    end
    m_rem[d] = nr; m_hold[d] = nh; m_early[d] = ne;
  endtask

  initial begin
    HRESET = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req_a[d] = '0; rdy_a[d] = 1'b1; sel_a[d] = 1'b0;
      trans_a[d] = HTRANS_IDLE; burst_a[d] = HBURST_SINGLE; lock_a[d] = 1'b0;
    end

    // Reset, first grant, RR rotation, INCR4 hold, lock, stall, keep-on-HSELM, RR wrap.
    tv[0]  = mk(1'b1, 4'b0000, 1'b1, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 0, 1'b1, 1'b0);
    tv[1]  = mk(1'b0, 4'b0100, 1'b1, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 2, 1'b0, 1'b0);
    tv[2]  = mk(1'b0, 4'b0000, 1'b1, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 2, 1'b1, 1'b0);
    tv[3]  = mk(1'b1, 4'b0000, 1'b1, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 0, 1'b1, 1'b0);
    tv[4]  = mk(1'b0, 4'b1111, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 0, 1'b0, 1'b0);
    tv[5]  = mk(1'b0, 4'b1111, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 1, 1'b0, 1'b0);
    tv[6]  = mk(1'b0, 4'b1111, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 2, 1'b0, 1'b0);
    tv[7]  = mk(1'b0, 4'b1111, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 3, 1'b0, 1'b0);
    tv[8]  = mk(1'b0, 4'b1111, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 0, 1'b0, 1'b0);
    tv[9]  = mk(1'b0, 4'b0010, 1'b1, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1, 1'b0, 1'b0);
    tv[10] = mk(1'b0, 4'b0110, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_INCR4,  1'b0, 1, 1'b0, 1'b1);
    tv[11] = mk(1'b0, 4'b0110, 1'b1, 1'b1, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 1, 1'b0, 1'b1);
    tv[12] = mk(1'b0, 4'b0110, 1'b1, 1'b1, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 1, 1'b0, 1'b1);
    tv[13] = mk(1'b0, 4'b0110, 1'b1, 1'b1, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 2, 1'b0, 1'b0);
    tv[14] = mk(1'b0, 4'b0001, 1'b1, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 0, 1'b0, 1'b0);
    tv[15] = mk(1'b0, 4'b1110, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 0, 1'b0, 1'b0);
    tv[16] = mk(1'b0, 4'b1110, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 0, 1'b0, 1'b0);
    tv[17] = mk(1'b0, 4'b1110, 1'b0, 1'b1, HTRANS_NONSEQ, HBURST_INCR16, 1'b0, 0, 1'b0, 1'b0);
    tv[18] = mk(1'b0, 4'b1110, 1'b0, 1'b1, HTRANS_NONSEQ, HBURST_INCR16, 1'b0, 0, 1'b0, 1'b0);
    tv[19] = mk(1'b0, 4'b1110, 1'b0, 1'b1, HTRANS_NONSEQ, HBURST_INCR16, 1'b0, 0, 1'b0, 1'b0);
    tv[20] = mk(1'b0, 4'b1110, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 1, 1'b0, 1'b0);
    tv[21] = mk(1'b0, 4'b0000, 1'b1, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1, 1'b0, 1'b0);
    tv[22] = mk(1'b0, 4'b0000, 1'b1, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1, 1'b1, 1'b0);
    tv[23] = mk(1'b0, 4'b0001, 1'b1, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++)
      dvec(0, tv[i].rst, tv[i].req, tv[i].rdy, tv[i].sel, tv[i].tr, tv[i].bu, tv[i].lk,
           tv[i].ea, tv[i].en, tv[i].eh, $sformatf("tv%0d", i));

    // Short back-to-back INCR bursts from port 3 with port 0 waiting.
    dvec(0, 1'b1, 4'b0000, 1'b1, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 0, 1'b1, 1'b0, "t5.rst");
    dvec(0, 1'b0, 4'b1000, 1'b1, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 3, 1'b0, 1'b0, "t5.gnt3");
    dvec(0, 1'b0, 4'b1001, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_INCR,   1'b0, 3, 1'b0, 1'b1, "t5.b1ns");
    dvec(0, 1'b0, 4'b1001, 1'b1, 1'b1, HTRANS_SEQ,    HBURST_INCR,   1'b0, 3, 1'b0, 1'b1, "t5.b1sq");
    dvec(0, 1'b0, 4'b1001, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_INCR,   1'b0, 3, 1'b0, 1'b1, "t5.b2ns");
    dvec(0, 1'b0, 4'b1001, 1'b1, 1'b1, HTRANS_SEQ,    HBURST_INCR,   1'b0, 3, 1'b0, 1'b1, "t5.b2sq");
    dvec(0, 1'b0, 4'b1001, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_INCR,   1'b0, 0, 1'b0, 1'b0, "t5.b3ns");

    // 3-port fixed priority, then reset in the middle of an INCR16.
    dvec(1, 1'b1, 4'b0000, 1'b1, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 0, 1'b1, 1'b0, "t6.rst");
    dvec(1, 1'b0, 4'b0100, 1'b1, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 2, 1'b0, 1'b0, "t6.gnt2");
    dvec(1, 1'b0, 4'b0110, 1'b1, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1, 1'b0, 1'b0, "t6.gnt1");
    dvec(1, 1'b0, 4'b0111, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 0, 1'b0, 1'b0, "t6.fx0");
    dvec(1, 1'b0, 4'b0111, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 1, 1'b0, 1'b0, "t6.fx1");
    dvec(1, 1'b0, 4'b0111, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 0, 1'b0, 1'b0, "t6.fx2");
    dvec(1, 1'b0, 4'b0111, 1'b1, 1'b1, HTRANS_NONSEQ, HBURST_INCR16, 1'b0, 0, 1'b0, 1'b1, "t6.i16ns");
    dvec(1, 1'b0, 4'b0111, 1'b1, 1'b1, HTRANS_SEQ,    HBURST_INCR16, 1'b0, 0, 1'b0, 1'b1, "t6.i16sq");
    dvec(1, 1'b1, 4'b0111, 1'b1, 1'b1, HTRANS_SEQ,    HBURST_INCR16, 1'b0, 0, 1'b1, 1'b0, "t6.midrst");
    dvec(1, 1'b0, 4'b0000, 1'b1, 1'b1, HTRANS_SEQ,    HBURST_INCR16, 1'b0, 0, 1'b1, 1'b0, "t6.after");

    // Random traffic on all three configurations.
    HRESET = 1'b1;
    step();
    for (int d = 0; d < 3; d++) model_step(d);
    for (int i = 0; i < 2000; i++) begin
      HRESET = ($urandom_range(0, 59) == 0);
      for (int d = 0; d < 3; d++) begin
        req_a[d]   = 4'($urandom_range(0, 15));
        rdy_a[d]   = ($urandom_range(0, 9) < 8);
        sel_a[d]   = ($urandom_range(0, 19) < 17);
        trans_a[d] = 2'($urandom_range(0, 3));
        burst_a[d] = 3'($urandom_range(0, 7));
        lock_a[d]  = ($urandom_range(0, 9) == 0);
      end
      step();
      for (int d = 0; d < 3; d++) begin
        model_step(d);
        check(d, m_idx[d], m_nop[d], m_hold[d], $sformatf("rnd%0d.d%0d", i, d));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
